// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage pipelined leading-zero counter and normaliser.
// Stage 1 registers the operand together with per-group all-zero flags and
// per-group leading-zero counts. Stage 2 picks the first non-zero group from
// the MSB side, forms the full count and shifts the operand left by it.
// Optional feature macro: LZC_NORM_LOD_EN adds mode_i (1 = count leading ones).
module lzc_norm_pipe #(
    parameter int  W     = 16,
    parameter int  G     = 4,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W-1:0]     data_i,
`ifdef LZC_NORM_LOD_EN
    input  logic             mode_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [W-1:0]     norm_o,
    output logic             zero_o
);

    localparam int NG  = W / G;
    localparam int GCW = $clog2(G);

    // Group 0 (the MSB-side group) lives in bit NG-1 so stage 2 can scan by
    // shifting left and always looking at the top element.
    logic                     v1;
    logic [W-1:0]             d1;
    logic [NG-1:0]            zf1;
    logic [NG-1:0][GCW-1:0]   gc1;

    logic                     v2;
    logic [CNT_W-1:0]         cnt2;
    logic [W-1:0]             norm2;
    logic                     zero2;

    logic                     ld1;
    logic                     ld2;
    logic [W-1:0]             cnt_src;
    logic [NG-1:0]            zf_c;
    logic [NG-1:0][GCW-1:0]   gc_c;
    logic [CNT_W-1:0]         cnt_c;
    logic [W-1:0]             norm_c;
    logic                     zero_c;

    // Each stage loads when it is empty or its content leaves this cycle.
    assign ld2     = ~v2 | ready_i;
    assign ld1     = ~v1 | ld2;
    assign ready_o = ld1;

    assign valid_o = v2;
    assign cnt_o   = cnt2;
    assign norm_o  = norm2;
    assign zero_o  = zero2;

    // Counting operand: inverted for leading-ones mode, data path untouched.
`ifdef LZC_NORM_LOD_EN
    assign cnt_src = mode_i ? ~data_i : data_i;
`else
    assign cnt_src = data_i;
`endif

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [G-1:0]   grp_bits;
        logic           zf_g;
        logic [GCW-1:0] gc_g;

        assign grp_bits = cnt_src[W-1-g*G -: G];

        // Per-group scan: count zeros from the group MSB until the first one.
        always_comb begin
            logic [G-1:0] t;
            // NOTE: every variable written here gets a default first, so no
            // path through the block leaves a value held (no latch inferred).
            t    = grp_bits;
            zf_g = 1'b1;
            gc_g = '0;
            for (int j = 0; j < G; j++) begin
                if (zf_g) begin
                    if (t[G-1]) zf_g = 1'b0;
                    else        gc_g = gc_g + GCW'(1);
                end
                t = t << 1;
            end
        end

        assign zf_c[NG-1-g] = zf_g;
        assign gc_c[NG-1-g] = gc_g;
    end

    // Stage 1 register: operand plus per-group partial results.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of evaluation order.
        if (rst) begin
            // NOTE: data registers are cleared as well as valid bits, so the
            // visible outputs are defined zeros straight out of reset.
            v1  <= 1'b0;
            d1  <= '0;
            zf1 <= '0;
            gc1 <= '0;
        end else if (ld1) begin
            v1 <= valid_i;
            if (valid_i) begin
                d1  <= data_i;
                zf1 <= zf_c;
                gc1 <= gc_c;
            end
        end
    end

    // Stage 2 combine: first non-zero group from the MSB side, then shift.
    always_comb begin
        logic [NG-1:0]          zf_t;
        logic [NG-1:0][GCW-1:0] gc_t;
        logic [CNT_W-1:0]       base;
        logic                   found;
        zf_t   = zf1;
        gc_t   = gc1;
        base   = '0;
        found  = 1'b0;
        cnt_c  = CNT_W'(W);
        zero_c = 1'b1;
        for (int k = 0; k < NG; k++) begin
            if (!found && !zf_t[NG-1]) begin
                cnt_c  = base + CNT_W'(gc_t[NG-1]);
                zero_c = 1'b0;
                found  = 1'b1;
            end
            base = base + CNT_W'(G);
            zf_t = zf_t << 1;
            gc_t = gc_t << GCW;
        end
        norm_c = d1 << cnt_c;
    end

    // Stage 2 register: final count, normalised operand and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            cnt2  <= '0;
            norm2 <= '0;
            zero2 <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                cnt2  <= cnt_c;
                norm2 <= norm_c;
                zero2 <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: scoreboard bench for lzc_norm_pipe (W=16, G=4).
// Driver pushes reference results on every input transfer; an independent
// monitor pops and compares on every output transfer.
module tb_lzc_norm_pipe;

    localparam int W     = 16;
    localparam int G     = 4;
    localparam int CNT_W = $clog2(W + 1);

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [W-1:0]     norm;
        logic             zero;
        int               acc_cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic             ready_o;
    logic [W-1:0]     data_i;
    logic             mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [CNT_W-1:0] cnt_o;
    logic [W-1:0]     norm_o;
    logic             zero_o;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   lat_chk  = 0;
    bit   rand_rdy = 0;

    lzc_norm_pipe #(.W(W), .G(G)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
`ifdef LZC_NORM_LOD_EN
        .mode_i  (mode_i),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .cnt_o   (cnt_o),
        .norm_o  (norm_o),
        .zero_o  (zero_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: position of the most significant set bit of the counted
    // operand; result is the original operand shifted by the count.
    function automatic exp_t model(input logic [W-1:0] d, input logic m);
        exp_t         e;
        logic [W-1:0] s;
        int           n;
        s = m ? ~d : d;
        n = W;
        for (int i = W - 1; i >= 0; i--) begin
            if (s[i]) begin
                n = W - 1 - i;
                break;
            end
        end
        e.cnt     = CNT_W'(n);
        e.norm    = (n >= W) ? '0 : (d << n);
        e.zero    = (n == W);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compares every output transfer and checks stall stability.
    initial begin
        bit               stalled;
        logic [CNT_W-1:0] h_cnt;
        logic [W-1:0]     h_norm;
        logic             h_zero;
        exp_t             e;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0;
            end else begin
                if (valid_o && !ready_i) begin
                    if (stalled) begin
                        check("stall_cnt", 32'(cnt_o), 32'(h_cnt));
                        check("stall_norm", 32'(norm_o), 32'(h_norm));
                        check("stall_zero", 32'(zero_o), 32'(h_zero));
                    end
                    stalled = 1;
                    h_cnt   = cnt_o;
                    h_norm  = norm_o;
                    h_zero  = zero_o;
                end else begin
                    stalled = 0;
                end
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 32'(norm_o), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("cnt", 32'(cnt_o), 32'(e.cnt));
                        check("norm", 32'(norm_o), 32'(e.norm));
                        check("zero", 32'(zero_o), 32'(e.zero));
                        if (lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
                    end
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [W-1:0] d, input logic m);
        exp_t e;
        int   waited;
        bit   done;
        waited  = 0;
        done    = 0;
        valid_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        while (!done) begin
            @(negedge clk);
            if (ready_o) begin
                e         = model(d, m);
                e.acc_cyc = cyc;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 100) begin
                check("send_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] d;
        d = W'($urandom);
        case ($urandom_range(0, 7))
            0:       d = '0;
            1:       d = '1;
            default: d = d >> $urandom_range(0, W - 1);
        endcase
        return d;
    endfunction

    initial begin
        int acc;
        exp_t e;
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'h1234;
        mode_i  = 1'b0;
        ready_i = 1'b1;

        // Reset held with valid_i asserted: nothing may load.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_cnt", 32'(cnt_o), 32'd0);
            check("rst_norm", 32'(norm_o), 32'd0);
            check("rst_zero", 32'(zero_o), 32'd0);
        end
        rst     = 1'b0;
        valid_i = 1'b0;
        check("post_rst_ready", 32'(ready_o), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("post_rst_valid", 32'(valid_o), 32'd0);
            check("post_rst_ready", 32'(ready_o), 32'd1);
        end
        @(posedge clk);
        #1;

        // Thermometer corners and back-to-back stream with exact latency.
        lat_chk = 1;
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0000, 1'b0);
        drain();
        send(16'h00F0, 1'b0);
        send(16'h0300, 1'b0);
        send(16'h4000, 1'b0);
        drain();
        for (int i = 0; i < W; i++) send(16'hFFFF >> i, 1'b0);
        drain();
        lat_chk = 0;

        // Backpressure: continuous valid, downstream stalled for 4 cycles.
        ready_i = 1'b0;
        acc     = 0;
        valid_i = 1'b1;
        data_i  = rand_op();
        repeat (4) begin
            @(negedge clk);
            if (ready_o) begin
                e         = model(data_i, 1'b0);
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
            data_i = rand_op();
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_ready_low", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        drain();

        // Reset with both stages full: in-flight operands are dropped.
        ready_i = 1'b0;
        send(16'h8000, 1'b0);
        send(16'h0F00, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        send(16'h0010, 1'b0);
        drain();

`ifdef LZC_NORM_LOD_EN
        lat_chk = 1;
        send(16'hF0A0, 1'b1);
        send(16'hFFFF, 1'b1);
        send(16'hF0A0, 1'b0);
        send(16'h0000, 1'b1);
        send(16'h0000, 1'b0);
        drain();
        lat_chk = 0;
`endif

        // Randomized traffic with random gaps and random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
`ifdef LZC_NORM_LOD_EN
            send(rand_op(), 1'($urandom_range(0, 1)));
`else
            send(rand_op(), 1'b0);
`endif
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        ready_i  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
